// File: rtl/i2c_target_regfile.sv
// I2C target (responder) with an 8-bit-addressed register file.
// Oversamples SCL/SDA on clk_i, decodes START/STOP/bytes, ACKs DEV_ADDR and
// supports sub-addressed writes with auto-increment and combined reads.
// Optional build macro I2C_TGT_STATS_EN adds saturating write/NACK counters.
module i2c_target_regfile #(
  parameter logic [6:0]  DEV_ADDR   = 7'h39,
  parameter int unsigned NREGS      = 256,
  parameter int unsigned FILTER_LEN = 3,
  parameter logic [7:0]  RST_VAL    = 8'h00
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe_o,
  output logic        wr_en_o,
  output logic [7:0]  wr_addr_o,
  output logic [7:0]  wr_data_o,
  input  logic [7:0]  rd_addr_i,
  output logic [7:0]  rd_data_o,
`ifdef I2C_TGT_STATS_EN
  output logic [15:0] wr_cnt_o,
  output logic [15:0] nack_cnt_o,
`endif
  output logic        busy_o
);

  localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int unsigned CW = $clog2(FILTER_LEN + 1);
  localparam logic [7:0]  PTR_MASK = 8'(NREGS - 1);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StSub, StSubAck, StWdata, StWack, StTx, StMack, StIgnore
  } state_e;

  // Index 0 = SCL, index 1 = SDA
  logic [1:0]    sync1_q, sync2_q, filt_q, filt_prev_q;
  logic [CW-1:0] cnt_q [2];

  logic scl_rise, scl_fall, sda_rise, sda_fall, sda_lvl;
  logic start, stop;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       phase_q, phase_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       nack_evt;

  logic [7:0] mem_q [NREGS];
  logic [7:0] byte_in, ptr_data, ptr_inc;

  // Two-flop synchronizer plus per-line glitch filter; idle bus level is high
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      filt_q      <= 2'b11;
      filt_prev_q <= 2'b11;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q     <= {sda_i, scl_i};
      sync2_q     <= sync1_q;
      filt_prev_q <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CW'(FILTER_LEN - 1)) begin
          filt_q[i] <= sync2_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign scl_rise = filt_q[0] & ~filt_prev_q[0];
  assign scl_fall = ~filt_q[0] & filt_prev_q[0];
  assign sda_rise = filt_q[1] & ~filt_prev_q[1];
  assign sda_fall = ~filt_q[1] & filt_prev_q[1];
  assign sda_lvl  = filt_q[1];
  assign start    = sda_fall & filt_q[0];
  assign stop     = sda_rise & filt_q[0];

  assign byte_in  = {shift_q[6:0], sda_lvl};
  assign ptr_data = mem_q[ptr_q[AW-1:0]];
  assign ptr_inc  = (ptr_q + 8'd1) & PTR_MASK;

  // Protocol state and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      phase_q   <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      phase_q   <= phase_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Next-state logic; phase_q marks "ACK driven" in ACK states and
  // "master ACK seen" in StMack
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    phase_d   = phase_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    nack_evt  = 1'b0;

    if (start) begin
      state_d   = StAddr;
      bit_cnt_d = '0;
      phase_d   = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else if (stop) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      phase_d   = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StIgnore: begin
        end
        StAddr: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (byte_in[7:1] == DEV_ADDR) begin
                rw_d    = byte_in[0];
                phase_d = 1'b0;
                state_d = StAddrAck;
              end else begin
                nack_evt = 1'b1;
                state_d  = StIgnore;
              end
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              phase_d   = 1'b0;
              bit_cnt_d = '0;
              if (rw_q) begin
                // First data bit goes out on the same falling edge that ends the ACK
                shift_d  = ptr_data;
                sda_oe_d = ~ptr_data[7];
                state_d  = StTx;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = StSub;
              end
            end
          end
        end
        StSub: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ptr_d   = byte_in & PTR_MASK;
              phase_d = 1'b0;
              state_d = StSubAck;
            end
          end
        end
        StSubAck, StWack: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              phase_d   = 1'b0;
              bit_cnt_d = '0;
              state_d   = StWdata;
            end
          end
        end
        StWdata: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              wr_en_d   = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = byte_in;
              ptr_d     = ptr_inc;
              phase_d   = 1'b0;
              state_d   = StWack;
            end
          end
        end
        StTx: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ptr_d   = ptr_inc;
              phase_d = 1'b0;
              state_d = StMack;
            end
          end else if (scl_fall) begin
            sda_oe_d = ~shift_q[7];
          end
        end
        StMack: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b0;
            end else begin
              shift_d   = ptr_data;
              sda_oe_d  = ~ptr_data[7];
              bit_cnt_d = '0;
              phase_d   = 1'b0;
              state_d   = StTx;
            end
          end else if (scl_rise) begin
            if (sda_lvl) begin
              nack_evt = 1'b1;
              state_d  = StIgnore;
            end else begin
              phase_d = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Register file; written one cycle after the strobe is issued so a peek at the
  // written address shows the old value while wr_en_o is high
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= RST_VAL;
    end else if (wr_en_q) begin
      mem_q[wr_addr_q[AW-1:0]] <= wr_data_q;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i[AW-1:0]];
  assign sda_oe_o  = sda_oe_q;
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign busy_o    = busy_q;

`ifdef I2C_TGT_STATS_EN
  logic [15:0] wr_cnt_q, nack_cnt_q;

  // Saturating event counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_cnt_q   <= '0;
      nack_cnt_q <= '0;
    end else begin
      if (wr_en_q && (wr_cnt_q != 16'hFFFF)) wr_cnt_q <= wr_cnt_q + 16'd1;
      if (nack_evt && (nack_cnt_q != 16'hFFFF)) nack_cnt_q <= nack_cnt_q + 16'd1;
    end
  end

  assign wr_cnt_o   = wr_cnt_q;
  assign nack_cnt_o = nack_cnt_q;
`else
  logic unused_nack_evt;
  assign unused_nack_evt = nack_evt;
`endif

endmodule

// File: doc/i2c_target_regfile.md
Name: i2c_target_regfile

Overview:
- Synthesizable I2C target (responder) for the I2C master that configures the HDMI transmitter: the other end of the same bus.
- Oversamples SCL/SDA on the system clock, decodes START/STOP/bytes, ACKs its 7-bit device address and holds an 8-bit-addressed register file.
- Supports write (sub-address + data, auto-increment) and combined read (repeated START).
- Used as the on-chip loopback target in HDMI bring-up benches and as a register-dump monitor.

Parameters:
DEV_ADDR, 7'h39, 7-bit device address (8-bit write address 0x72 / read address 0x73)
NREGS, 256, register count; sub-address wraps modulo NREGS (must be a power of 2, at most 256)
FILTER_LEN, 3, consecutive equal samples needed to accept an SCL/SDA level change
RST_VAL, 8'h00, reset value of every register

Ports:
clk_i  in  1  system clock, the only clock
rst_i  in  1  asynchronous active-high reset
scl_i  in  1  bus SCL (asynchronous to clk_i)
sda_i  in  1  bus SDA input (asynchronous)
sda_oe_o  out  1  1 = pull SDA low; 0 = release (open-drain)
wr_en_o  out  1  one-cycle pulse per accepted data byte
wr_addr_o  out  8  register address of the accepted byte
wr_data_o  out  8  accepted data byte
rd_addr_i  in  8  side-band register peek address
rd_data_o  out  8  register[rd_addr_i], combinational
busy_o  out  1  1 between START and STOP

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, pointer 0, registers set to RST_VAL.
  - Reset mid-transfer releases SDA in the same edge.
- Input path: 2-FF synchronizer per line, then a glitch filter.
  - Filtered level changes only after FILTER_LEN identical samples.
  - Pulses shorter than FILTER_LEN clk cycles are ignored.
  - scl_rise/scl_fall/sda_rise/sda_fall are single-cycle strobes derived from the filtered levels.
- START = sda_fall while SCL high; STOP = sda_rise while SCL high. Both have priority over any bit event in the same cycle.
  - START from any state goes to ADDR with bit count 0 (repeated START included); the pointer is kept.
  - STOP from any state goes to IDLE and releases SDA.
- Bits are sampled on scl_rise, MSB first. sda_oe_o changes only on scl_fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - Address match, R/W=0 goes to ADDR_ACK(W).
    - Address match, R/W=1 goes to ADDR_ACK(R).
    - Mismatch goes to IGNORE, SDA never driven.
  - ADDR_ACK: drive low for one SCL period. W then goes to SUBADDR; R loads the shift register with reg[ptr] and goes to TX.
  - SUBADDR: 8 bits; load ptr, then SUB_ACK, then WDATA.
  - WDATA: 8 bits. On the 8th scl_rise, pulse wr_en_o with wr_addr_o=ptr and wr_data_o=byte, write the register, ptr = ptr+1 mod NREGS, then WACK (ACK) and back to WDATA.
  - TX: drive SDA low for 0 bits and release for 1 bits, over 8 bits; ptr increments after the 8th bit. Then MACK: release SDA and sample the master bit.
    - Master ACK (0): reload reg[ptr], back to TX.
    - Master NACK (1): go to IGNORE.
  - IGNORE: release SDA until START/STOP.
- ACK is always given on write bytes; there is no NACK-on-full.
- Write-port and side-band peek collision: rd_data_o shows the old value in the write cycle and the new value after.
- No clock stretching: SCL is never driven.

Optional Feature:
- Macro: I2C_TGT_STATS_EN.
- Defined: adds ports wr_cnt_o[15:0] (accepted data bytes) and nack_cnt_o[15:0] (address phases not matched, plus reads ended by master NACK).
  - Both counters saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Write 0x72,0x41,0x10 then STOP.
  - Target ACKs 3 times (sda_oe_o=1 during each ACK SCL-high).
  - Exactly one wr_en_o pulse with addr 0x41, data 0x10.
  - rd_data_o(0x41)=0x10; busy_o falls after STOP.
- Write 0x74,... (wrong address): sda_oe_o stays 0 for the whole transfer; no wr_en_o; registers unchanged.
  - With STATS enabled, nack_cnt_o=1.
- Preload 0x41=0x10, 0x42=0xA5. Send 0x72,0x41, repeated START, 0x73.
  - Read byte 0x10; master ACK; read 0xA5; master NACK then STOP.
  - SDA released after the NACK.
- Write 0x72,0xFF,0x11,0x22: reg[0xFF]=0x11, reg[0x00]=0x22 (pointer wrap).
- Insert a 2-cycle SCL low glitch mid-byte with FILTER_LEN=3: no extra bit counted; the byte is received correctly.
- Assert rst_i while the target is driving an ACK: sda_oe_o=0 immediately.
  - After release, a fresh write transaction completes normally.
